// File: rtl/alarm_chime.sv
// alarm_chime
//   Watches the running BCD time and rings when it reaches the alarm setting
//   (hh:mm:00). While ringing, the LED blinks and the buzzer plays a square
//   tone during the LED-on phases. A ring ends after RING_SEC seconds, on a
//   stop key, or by snoozing for SNOOZE_MIN minutes and then ringing again.
//   Dropping alarm_en silences everything immediately.
//
//   Build option: define ALARM_CHIME_TONE_EN to build the tone divider.
//   Without it, the buzzer is tied low and the tone divider is not built.
//   LED, ringing, snoozing and state behaviour are the same in both builds.
module alarm_chime #(
  parameter int BLINK_DIV  = 12_500_000,  // clk cycles per LED toggle (>= 2)
  parameter int TONE_DIV   = 25_000,      // clk cycles per buzzer half-period (>= 1)
  parameter int RING_SEC   = 60,          // ring length in seconds (1..255)
  parameter int SNOOZE_MIN = 5            // snooze length in minutes (1..15)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] min_l,
  input  logic [3:0] min_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] hour_h,
  input  logic [3:0] alarm_min_l,
  input  logic [3:0] alarm_min_h,
  input  logic [3:0] alarm_hour_l,
  input  logic [3:0] alarm_hour_h,
  input  logic [2:0] adjust,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       ringing,
  output logic       snoozing,
  output logic       led,
  output logic       buzzer
);

  localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [7:0]         RING_LAST  = 8'(RING_SEC - 1);
  localparam logic [9:0]         SNZ_LAST   = 10'(SNOOZE_MIN * 60 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         ring_cnt_q, ring_cnt_d;
  logic [9:0]         snz_cnt_q, snz_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               led_q, led_d;

  logic               match;
  logic               match_q;
  logic               trigger;
  logic [3:0]         sec_l_q;
  logic               sec_tick;

  // The alarm fires only on the first cycle of hh:mm:00 and never while the
  // user is editing, so holding the time at the alarm value rings once.
  assign match = ({hour_h, hour_l, min_h, min_l} ==
                  {alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l}) &&
                 (sec_h == 4'd0) && (sec_l == 4'd0) && (adjust == 3'd0);

  assign trigger  = match & ~match_q & alarm_en;
  assign sec_tick = (sec_l != sec_l_q);

  // Edge detectors for the match condition and the seconds digit.
  // match_q comes out of reset high so a time already equal to the alarm
  // at reset release is not seen as a new match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b1;
      sec_l_q <= 4'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      match_q <= match;
      sec_l_q <= sec_l;
    end
  end

  // Next-state logic for the ring/snooze controller, counters and LED.
  always_comb begin
    // NOTE: every signal gets a default first; a path that left one unassigned would infer a latch.
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    snz_cnt_d   = snz_cnt_q;
    blink_cnt_d = blink_cnt_q;
    led_d       = led_q;

    if (!alarm_en) begin
      // Disarm overrides every other transition.
      state_d     = IDLE;
      led_d       = 1'b0;
      blink_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          led_d = 1'b0;
          if (trigger) begin
            state_d     = RING;
            ring_cnt_d  = '0;
            blink_cnt_d = '0;
            led_d       = 1'b1;
          end
        end

        RING: begin
          if (stop) begin
            // stop wins over a snooze pressed in the same cycle
            state_d = IDLE;
            led_d   = 1'b0;
          end else if (snooze) begin
            state_d   = SNOOZE;
            snz_cnt_d = '0;
            led_d     = 1'b0;
          end else if (sec_tick && (ring_cnt_q == RING_LAST)) begin
            state_d = IDLE;
            led_d   = 1'b0;
          end else begin
            if (sec_tick) begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              led_d       = ~led_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
        end

        SNOOZE: begin
          led_d = 1'b0;
          if (stop) begin
            state_d = IDLE;
          end else if (sec_tick) begin
            if (snz_cnt_q == SNZ_LAST) begin
              // Re-ring with a fresh ring period and blink phase.
              state_d     = RING;
              ring_cnt_d  = '0;
              blink_cnt_d = '0;
              led_d       = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q + 10'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          led_d   = 1'b0;
        end
      endcase
    end
  end

  // Controller registers; LED is registered so it rises with ringing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      led_q       <= led_d;
    end
  end

  assign ringing  = (state_q == RING);
  assign snoozing = (state_q == SNOOZE);
  assign led      = led_q;

`ifdef ALARM_CHIME_TONE_EN
  localparam int                TONE_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              tone_run;

  // The tone advances only while the LED is on now and stays on across this
  // edge, so the buzzer drops on the same edge as the LED and each LED-on
  // phase starts with a cleared divider.
  assign tone_run = (state_q == RING) && led_q && (state_d == RING) && led_d;

  // Tone divider next state: toggle every TONE_DIV cycles while tone_run.
  always_comb begin
    tone_cnt_d = '0;
    buzzer_d   = 1'b0;
    if (tone_run) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        buzzer_d   = ~buzzer_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        buzzer_d   = buzzer_q;
      end
    end
  end

  // Tone divider and buzzer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;
`else
  assign buzzer = 1'b0;
`endif

endmodule
